// File: rtl/hilo_capture_pkg.sv
// Shared definitions for the HI/LO multiply-capture block: FSM state
// encoding, datapath widths and the overflow test on a 64-bit product.
package hilo_capture_pkg;

  localparam int WORD_W = 32;
  localparam int PROD_W = 64;
  // Settle counter width; SETTLE_CYCLES is limited to 1..15.
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // A product fits in 32 signed bits only when its upper word is a pure
  // sign extension of bit 31.
  function automatic logic prod_ovf(input logic [PROD_W-1:0] p);
    return p[PROD_W-1:WORD_W] != {WORD_W{p[WORD_W-1]}};
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// HI/LO register pair. Each word is loaded either from its half of the
// captured product or from direct write data, and one word is muxed
// combinationally onto the read port (rd_sel_i: 0 = LO, 1 = HI).
module hilo_reg
  import hilo_capture_pkg::*;
(
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              cap_en_i,
  input  logic [PROD_W-1:0] cap_data_i,
  input  logic              wr_hi_i,
  input  logic              wr_lo_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              rd_sel_i,
  output logic [WORD_W-1:0] rdata_o
);

  // Word 0 is LO (product[31:0]), word 1 is HI (product[63:32]).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_word
      logic              wr_en;
      logic [WORD_W-1:0] word_q;
      logic [WORD_W-1:0] word_d;

      assign wr_en = (gi == 0) ? wr_lo_i : wr_hi_i;

      // Next word value: capture takes precedence over a direct write.
      always_comb begin
        word_d = word_q;
        if (cap_en_i) begin
          word_d = cap_data_i[gi*WORD_W +: WORD_W];
        end else if (wr_en) begin
          word_d = wdata_i;
        end
      end

      // Word storage with synchronous clear.
      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          word_q <= '0;
        end else begin
          word_q <= word_d;
        end
      end
    end
  endgenerate

  assign rdata_o = rd_sel_i ? g_word[1].word_q : g_word[0].word_q;

endmodule

// File: rtl/hilo_capture.sv
// Multiply-capture controller. On an accepted start it registers the
// operands toward an external multiplier, waits SETTLE_CYCLES for the
// product to settle, then loads HI/LO from the product and pulses done.
// Optional build macro: HILO_OVF_FLAG_EN enables the registered overflow
// flag; without it ovf is constant 0.
module hilo_capture
  import hilo_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  output logic [WORD_W-1:0] mul_q,
  output logic [WORD_W-1:0] mul_m,
  input  logic [PROD_W-1:0] product,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [WORD_W-1:0] wdata,
  input  logic              rd_sel,
  output logic [WORD_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  // Counter reload: WAIT lasts SETTLE_CYCLES edges, giving a total latency
  // of SETTLE_CYCLES+1 edges from the start edge to the HI/LO update.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  qop_q, qop_d;
  logic [WORD_W-1:0]  mop_q, mop_d;
  logic               done_q, done_d;
  logic               start_ok;
  logic               cap_en;
  logic               wr_ok;
  logic               wr_hi_ok;
  logic               wr_lo_ok;

  // Next-state, counter and operand logic; start is only honoured in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    qop_d    = qop_q;
    mop_d    = mop_q;
    done_d   = 1'b0;
    start_ok = 1'b0;
    cap_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          qop_d    = op_a;
          mop_d    = op_b;
          cnt_d    = SETTLE_LOAD;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CAPTURE: begin
        cap_en  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Direct writes only land in IDLE and lose to a same-cycle start.
  assign wr_ok    = (state_q == IDLE) && !start;
  assign wr_hi_ok = wr_ok && wr_hi;
  assign wr_lo_ok = wr_ok && wr_lo;

  // Control and operand registers; clear aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qop_q   <= '0;
      mop_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qop_q   <= qop_d;
      mop_q   <= mop_d;
      done_q  <= done_d;
    end
  end

  assign mul_q = qop_q;
  assign mul_m = mop_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

  hilo_reg u_hilo_reg (
    .clk_i      (clock),
    .srst_i     (clear),
    .cap_en_i   (cap_en),
    .cap_data_i (product),
    .wr_hi_i    (wr_hi_ok),
    .wr_lo_i    (wr_lo_ok),
    .wdata_i    (wdata),
    .rd_sel_i   (rd_sel),
    .rdata_o    (rdata)
  );

`ifdef HILO_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // Overflow is judged on the captured product and forgotten as soon as
  // HI/LO are re-targeted by a new operation or a direct write.
  always_comb begin
    ovf_d = ovf_q;
    if (cap_en) begin
      ovf_d = prod_ovf(product);
    end else if (start_ok || wr_hi_ok || wr_lo_ok) begin
      ovf_d = 1'b0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clock) begin
    if (clear) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_capture.sv
// Bench for hilo_capture with SETTLE_CYCLES=2 and a behavioural signed
// multiplier closing the loop from mul_q/mul_m to product.
module tb_hilo_capture;

  localparam int SETTLE = 2;
`ifdef HILO_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a  = '0;
  logic [31:0] op_b  = '0;
  logic [31:0] mul_q;
  logic [31:0] mul_m;
  logic [63:0] product;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wdata = '0;
  logic        rd_sel = 1'b0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        ovf;

  always #5 clock = ~clock;

  // External multiplier model.
  logic signed [63:0] pa, pb;
  assign pa      = {{32{mul_q[31]}}, mul_q};
  assign pb      = {{32{mul_m[31]}}, mul_m};
  assign product = pa * pb;

  hilo_capture #(.SETTLE_CYCLES(SETTLE)) dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .mul_q   (mul_q),
    .mul_m   (mul_m),
    .product (product),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wdata   (wdata),
    .rd_sel  (rd_sel),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an operation is "edges left until HI/LO update".
  logic [31:0] m_hi = '0, m_lo = '0, m_q = '0, m_m = '0;
  bit          m_ovf = 0, m_done = 0;
  int          m_left = 0;

  function automatic void model_edge(input bit clr, input bit st, input logic [31:0] a,
                                     input logic [31:0] b, input bit whi, input bit wlo,
                                     input logic [31:0] wd);
    longint p;
    if (clr) begin
      m_hi = '0; m_lo = '0; m_q = '0; m_m = '0;
      m_ovf = 0; m_done = 0; m_left = 0;
      return;
    end
    m_done = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        p = longint'($signed(m_q)) * longint'($signed(m_m));
        m_hi = p[63:32];
        m_lo = p[31:0];
        m_done = 1;
        m_ovf = OVF_EN && (p > 64'sd2147483647 || p < -64'sd2147483648);
      end
    end else if (st) begin
      m_q = a; m_m = b; m_left = SETTLE + 1; m_ovf = 0;
    end else if (whi || wlo) begin
      if (whi) m_hi = wd;
      if (wlo) m_lo = wd;
      m_ovf = 0;
    end
  endfunction

  // One clock edge: drive, let the DUT clock, update model, compare.
  task automatic step(input bit clr, input bit st, input logic [31:0] a, input logic [31:0] b,
                      input bit whi, input bit wlo, input logic [31:0] wd);
    clear = clr; start = st; op_a = a; op_b = b;
    wr_hi = whi; wr_lo = wlo; wdata = wd;
    @(posedge clock);
    model_edge(clr, st, a, b, whi, wlo, wd);
    #1;
    $display("edge t=%0t clr=%0d st=%0d a=%h b=%h whi=%0d wlo=%0d wd=%h -> busy=%0d done=%0d hi/lo exp=%h/%h",
             $time, clr, st, a, b, whi, wlo, wd, busy, done, m_hi, m_lo);
    check("busy",  64'(busy),  64'(m_left > 0));
    check("done",  64'(done),  64'(m_done));
    check("ovf",   64'(ovf),   64'(m_ovf));
    check("mul_q", 64'(mul_q), 64'(m_q));
    check("mul_m", 64'(mul_m), 64'(m_m));
    rd_sel = 1'b0; #1;
    check("lo", 64'(rdata), 64'(m_lo));
    rd_sel = 1'b1; #1;
    check("hi", 64'(rdata), 64'(m_hi));
    @(negedge clock);
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic read_check(input string tag, input bit sel, input logic [31:0] exp);
    rd_sel = sel; #1;
    check(tag, 64'(rdata), 64'(exp));
  endtask

  // Start at edge 0, idle through edges 1..3; done must be up after edge 3.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    step(0, 1, a, b, 0, 0, '0);
    idle();
    check("no_early_done", 64'(done), 64'd0);
    idle();
    check("no_early_done", 64'(done), 64'd0);
    idle();
    check("done_at_edge3", 64'(done), 64'd1);
  endtask

  initial begin
    @(negedge clock);
    step(1, 1, 32'h5, 32'h6, 1, 1, 32'hFFFF);
    step(1, 0, '0, '0, 0, 0, '0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mul_q", 64'(mul_q), 64'd0);
    read_check("rst_hi", 1, 32'h0);

    // 2 * 5
    run_op(32'd2, 32'd5);
    read_check("s1_hi", 1, 32'h00000000);
    read_check("s1_lo", 0, 32'h0000000A);
    check("s1_ovf", 64'(ovf), 64'd0);
    idle();

    // -2 * 5
    run_op(32'hFFFFFFFE, 32'd5);
    read_check("s2_hi", 1, 32'hFFFFFFFF);
    read_check("s2_lo", 0, 32'hFFFFFFF6);
    check("s2_ovf", 64'(ovf), 64'd0);
    idle();

    // 0x10000 * 0x10000 overflows 32 bits
    run_op(32'h00010000, 32'h00010000);
    read_check("s3_hi", 1, 32'h00000001);
    read_check("s3_lo", 0, 32'h00000000);
    check("s3_ovf", 64'(ovf), 64'(OVF_EN));
    idle();

    // Second start while busy is ignored
    step(0, 1, 32'd2, 32'd5, 0, 0, '0);
    step(0, 1, 32'd7, 32'd9, 0, 0, '0);
    check("s4_mul_q", 64'(mul_q), 64'd2);
    idle();
    idle();
    check("s4_done", 64'(done), 64'd1);
    idle();
    check("s4_single_done", 64'(done), 64'd0);

    // Clear at edge 2 aborts the operation
    step(0, 1, 32'd3, 32'd3, 0, 0, '0);
    idle();
    step(1, 0, '0, '0, 0, 0, '0);
    check("s5_busy", 64'(busy), 64'd0);
    idle();
    check("s5_no_done", 64'(done), 64'd0);
    read_check("s5_lo", 0, 32'h0);
    idle();

    // Direct write HI, then wr_lo together with start is dropped
    step(0, 0, '0, '0, 1, 0, 32'h1234);
    read_check("s6_hi", 1, 32'h1234);
    step(0, 0, '0, '0, 0, 1, 32'h55);
    step(0, 1, 32'd4, 32'd4, 0, 1, 32'hDEAD);
    read_check("s6_lo_kept", 0, 32'h55);
    idle();
    idle();
    idle();
    read_check("s6_lo_cap", 0, 32'd16);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b, wd;
      int sel;
      sel = $urandom_range(0, 2);
      a = (sel == 0) ? $urandom : (sel == 1) ? 32'($urandom_range(0, 255)) - 32'd128 : 32'h00010000 << $urandom_range(0, 8);
      b = (sel == 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128;
      wd = $urandom;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, a, b,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, wd);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hilo_capture.md
HILO_CAPTURE -- requirements
Module: hilo_capture

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, default 2, cycles operands are held stable before the product is sampled (legal range 1..15).
REQ-002 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clock  in  1  sole clock; all state changes on its rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  request to multiply op_a by op_b.
- op_a  in  32  signed multiplicand.
- op_b  in  32  signed multiplier.
- mul_q  out  32  registered operand driven to the external multiplier Q input.
- mul_m  out  32  registered operand driven to the external multiplier M input.
- product  in  64  signed product returned by the multiplier.
- wr_hi  in  1  direct write of HI.
- wr_lo  in  1  direct write of LO.
- wdata  in  32  data for direct writes.
- rd_sel  in  1  read select: 0 selects LO, 1 selects HI.
- rdata  out  32  combinational mux of HI or LO.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO have been updated from the product.
- ovf  out  1  product does not fit in 32 signed bits.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, CAPTURE.
REQ-004 In IDLE with start=1, SHALL register op_a->mul_q and op_b->mul_m, load the settle counter with SETTLE_CYCLES-1, and go to WAIT.
REQ-005 In WAIT, SHALL decrement the counter each cycle and go to CAPTURE on the edge where the counter is 0.
REQ-006 On the edge leaving CAPTURE, SHALL write HI=product[63:32] and LO=product[31:0], set done=1 for exactly one cycle, and return to IDLE.
REQ-007 Latency: HI/LO update and done rise SETTLE_CYCLES+1 edges after the edge that sampled start.
REQ-008 busy SHALL be 1 in WAIT and CAPTURE and 0 in IDLE.
REQ-009 start while busy=1 SHALL be ignored, with no queuing.
REQ-010 mul_q/mul_m SHALL hold their value from the start edge until the next accepted start.
REQ-011 Direct writes in IDLE SHALL apply as follows: wr_hi loads HI from wdata; wr_lo loads LO from wdata; both asserted load both.
REQ-012 wr_hi/wr_lo SHALL be dropped while busy=1, and SHALL be dropped when start=1 in the same IDLE cycle (start wins).
REQ-013 rdata SHALL reflect HI/LO combinationally; a read in the done cycle SHALL return the new value.
REQ-014 No arithmetic SHALL be performed inside the block; product is taken bit-exact and is not truncated or sign-altered.

Reset
REQ-015 clear=1 at a clock edge SHALL force state IDLE, counter 0, HI=0, LO=0, mul_q=0, mul_m=0, done=0, ovf=0, busy=0.
REQ-016 clear SHALL take priority over start, wr_hi/wr_lo, and any in-flight operation; an aborted operation SHALL NOT pulse done or update HI/LO.

Configuration
REQ-017 With HILO_OVF_FLAG_EN defined, ovf SHALL be registered on the capture edge as 1 when product[63:32] != {32{product[31]}}, and cleared on the next accepted start, any direct write, or clear.
REQ-018 Without HILO_OVF_FLAG_EN, ovf SHALL be tied to 0 and no overflow logic SHALL be synthesized.

Structure
REQ-019 A shared package SHALL hold the FSM state enum (IDLE/WAIT/CAPTURE), the 32-bit word width, and the 64-bit product width constants.
REQ-020 HI/LO storage with its write-enable/mux logic SHALL be one sub-module, hilo_reg; the FSM and counter SHALL remain in hilo_capture.

Verification
REQ-021 Benches SHALL use SETTLE_CYCLES=2 and a real or model multiplier on mul_q/mul_m -> product, and SHALL cover:
- op_a=2, op_b=5, start at edge 0 -> done at edge 3; HI=0x00000000, LO=0x0000000A; ovf=0.
- op_a=-2, op_b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF6; ovf=0 (with HILO_OVF_FLAG_EN).
- op_a=0x00010000, op_b=0x00010000 -> HI=0x00000001, LO=0x00000000; ovf=1 with macro, 0 without.
- Second start at edge 1 with op_a=7 -> ignored; mul_q stays 2; a single done pulse.
- clear at edge 2 of an operation -> no done; HI=LO=0; busy=0 at edge 2.
- IDLE, wr_hi=1, wdata=0x1234, then rd_sel=1 -> rdata=0x1234; wr_lo together with start -> LO unchanged before capture.
